beta_cmp_flag_gen: RTL
======================

# beta_cmp_flag_gen

Pipelined flag generator feeding the BETA ALU compare unit. It accepts operand pairs with a compare function code, computes A−B, and presents registered Z, V, N flags plus the matching CFN. These outputs connect directly to the CMP block's Z/V/N/CFN inputs. The block uses a two-stage valid/ready pipeline with backpressure, a synchronous flush, and a saturating issued-compare counter for performance monitoring.

## Interface
- CNT_W, default 16: width of the issued-compare counter.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: operand pair and cfn_in are valid.
- in_ready  out  1: block accepts the input this cycle.
- a  in  32: operand A.
- b  in  32: operand B.
- cfn_in  in  2 [2:1]: compare function. 01 = CMPEQ, 10 = CMPLT, 11 = CMPLE, 00 = reserved.
- flush  in  1: synchronous; drops all in-flight entries.
- out_valid  out  1: Z/V/N/CFN hold a result.
- out_ready  in  1: downstream consumes the result.
- Z, V, N  out  1 each: zero, overflow, and negative flags of A−B.
- CFN  out  2 [2:1]: cfn_in travelling with the result.
- cmp_count  out  CNT_W: number of results consumed, saturating.

## Operation
- Stage 1 (S1) registers a, b, cfn_in and s1_valid on the cycle where in_valid && in_ready.
- Stage 2 (S2) computes d = S1.a − S1.b (32-bit, wrap-around) and registers:
  - Z = (d == 0)
  - N = d[31]
  - V = (a[31] & ~b[31] & ~d[31]) | (~a[31] & b[31] & d[31])
  - CFN = S1.cfn
  - out_valid = s1_valid
- s2_free = ~out_valid | out_ready.
- in_ready = ~s1_valid | s2_free. It is combinational, with no dependency on in_valid.
- S1→S2 advance happens when s1_valid && s2_free.
- S1 holds its contents when S1 is full and S2 is stalled.
- S1 loads new data when S1 is empty or advancing. An S1 advance and a new load in the same cycle is legal.
- When out_valid=1 and out_ready=0, Z/V/N/CFN stay stable until consumed.
- cfn_in=00 passes through unchanged. Flags are computed normally; interpretation is left to CMP.
- cmp_count increments by 1 on each out_valid && out_ready. It holds at all-ones and never wraps to 0.
- flush=1:
  - s1_valid and out_valid are cleared next edge.
  - Input presented in the same cycle is dropped, even though in_ready may read 1.
  - cmp_count still counts a handshake completing in the flush cycle.
  - Data registers are not cleared.
- Reset (async assert, any time, including mid-transfer):
  - s1_valid=0, out_valid=0, Z=V=N=0, CFN=00, cmp_count=0.
  - S1 data registers are cleared to 0.
  - in_ready reads 1 while reset is asserted and afterwards.

## Timing
- Latency: input accepted at edge k gives out_valid=1 after edge k+1, so the result is visible in cycle k+1.
- Throughput: 1 compare/cycle while out_ready=1.
- Capacity: 2 entries (S1 and S2). With out_ready held 0, in_ready drops after two accepts.
- After one pop with S1 and S2 full, in_ready=1 in that same cycle (pass-through of out_ready).
- No combinational path from a/b to the outputs. The only combinational input→output path is out_ready→in_ready.
- Release of rst_n must be synchronous to clk (handled outside the block). The first accept is legal on the first edge after release.

## Test plan
- Equality: a=5, b=5, cfn_in=01 → one cycle after accept, out_valid=1, Z=1, N=0, V=0, CFN=01.
- Less-than: a=3, b=7, cfn_in=10 → Z=0, N=1, V=0, CFN=10. Stream 8 back-to-back pairs with out_ready=1 → 8 results on consecutive cycles, in order, and cmp_count=8.
- Overflow:
  - a=0x80000000, b=1, cfn_in=11 → d=0x7FFFFFFF, N=0, V=1, Z=0.
  - a=0x7FFFFFFF, b=0xFFFFFFFF → d=0x80000000, N=1, V=1.
- Backpressure: out_ready=0, offer 3 inputs → only 2 accepted and in_ready=0 on the third. Outputs stay stable. Raise out_ready → results drain in order, then the third is accepted.
- Flush and reset: with 2 entries in flight, pulse flush → out_valid=0 next cycle and nothing emitted. Assert rst_n=0 mid-stream with cmp_count=5 → all outputs 0 immediately, with no clock edge needed.
- Saturation: with CNT_W=4, complete 20 handshakes → cmp_count=15 and it stays 15.

Source files
------------

// File: rtl/beta_cmp_flag_gen.sv
// Two-stage valid/ready flag generator for the BETA compare unit: registers A-B
// derived Z/V/N flags with the compare function code, plus a saturating count.
module beta_cmp_flag_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [2:1]       cfn_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic [2:1]       CFN,
  output logic [CNT_W-1:0] cmp_count
);

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_a_q, s1_a_d;
  logic [31:0] s1_b_q, s1_b_d;
  logic [2:1]  s1_cfn_q, s1_cfn_d;

  // Stage 2 state (drives the outputs directly)
  logic        out_valid_q, out_valid_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        n_q, n_d;
  logic [2:1]  cfn_q, cfn_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        s2_free;
  logic        s1_adv;
  logic        s1_load;
  logic        pop;
  logic [31:0] diff;

  // out_ready -> in_ready is the only combinational input-to-output path.
  assign s2_free  = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_free;
  assign s1_adv   = s1_valid_q & s2_free;
  assign s1_load  = in_valid & in_ready & ~flush;
  assign pop      = out_valid_q & out_ready;
  assign diff     = s1_a_q - s1_b_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_cfn_d    = s1_cfn_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    v_d         = v_q;
    n_d         = n_q;
    cfn_d       = cfn_q;
    cnt_d       = cnt_q;

    if (s1_load) begin
      s1_a_d   = a;
      s1_b_d   = b;
      s1_cfn_d = cfn_in;
    end

    if (flush)        s1_valid_d = 1'b0;
    else if (s1_load) s1_valid_d = 1'b1;
    else if (s1_adv)  s1_valid_d = 1'b0;

    if (s1_adv) begin
      z_d   = (diff == 32'd0);
      n_d   = diff[31];
      v_d   = (s1_a_q[31] & ~s1_b_q[31] & ~diff[31]) |
              (~s1_a_q[31] & s1_b_q[31] & diff[31]);
      cfn_d = s1_cfn_q;
    end

    if (flush)        out_valid_d = 1'b0;
    else if (s2_free) out_valid_d = s1_valid_q;

    // Saturate at all-ones; a handshake during flush still counts.
    if (pop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cfn_q    <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      cfn_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cfn_q    <= s1_cfn_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
      cfn_q       <= cfn_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign V         = v_q;
  assign N         = n_q;
  assign CFN       = cfn_q;
  assign cmp_count = cnt_q;

endmodule
